// File: rtl/mips_pkg.sv
// Shared types for the MIPS MEM stage: FSM states,
// WB source encodings and the EX/MEM control bundle.
package mips_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } mstate_t;

   localparam logic [1:0] MTR_ALU = 2'd0;
   localparam logic [1:0] MTR_MEM = 2'd1;
   localparam logic [1:0] MTR_PC  = 2'd2;

   typedef struct packed {
      logic       memrd;
      logic       memwr;
      logic       bbeq;
      logic       bbne;
      logic       bblez;
      logic       bbgtz;
      logic       jump;
      logic       regwr;
      logic [1:0] memtoreg;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   function automatic logic br_taken(
      input ctrl_t c,
      input logic  z,
      input logic  n
   );
      br_taken = (c.bbeq  &  z)
               | (c.bbne  & ~z)
               | (c.bblez & (n | z))
               | (c.bbgtz & ~n & ~z);
   endfunction

endpackage

// File: rtl/exmem_stage_dmem_fsm.sv
// Data-memory access sequencer: req/ack handshake,
// timeout counter and the pipeline stall it implies.
module dmem_fsm
   import mips_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic clr,
   input  logic memop,
   input  logic dm_ack,
   output logic dm_req,
   output logic stall,
   output logic done,
   output logic tmo
);

   localparam int CW = $clog2(TIMEOUT + 1);

   mstate_t       state;
   mstate_t       state_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      dm_req   = 1'b0;
      done     = 1'b0;
      tmo      = 1'b0;
      stall    = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_nx = '0;
            if (memop) state_nx = ACCESS;
         end
         ACCESS: begin
            dm_req = 1'b1;
            if (dm_ack) begin
               done     = 1'b1;
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               // last allowed request cycle: give up
               tmo      = 1'b1;
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      stall = memop & ~done & ~tmo;
   end

endmodule

// File: rtl/exmem_stage.sv
// MEM stage: EX/MEM register, branch/jump resolve,
// data-memory access and MEM/WB register.
module exmem_stage
   import mips_pkg::*;
#(
   parameter int DWIDTH  = 32,
   parameter int AWIDTH  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [DWIDTH-1:0] ex_aluresult,
   input  logic [DWIDTH-1:0] ex_storedata,
   input  logic [4:0]        ex_dstaddr,
   input  logic              ex_memrd,
   input  logic              ex_memwr,
   input  logic              ex_bbeq,
   input  logic              ex_bbne,
   input  logic              ex_bblez,
   input  logic              ex_bbgtz,
   input  logic              ex_jump,
   input  logic              ex_regwr,
   input  logic [1:0]        ex_memtoreg,
   input  logic [AWIDTH-1:0] ex_branaddr,
   input  logic [AWIDTH-1:0] ex_jmpaddr,
   input  logic [AWIDTH-1:0] ex_pcnext,
   input  logic [DWIDTH-1:0] dm_rdata,
   input  logic              dm_ack,
   output logic              dm_req,
   output logic              dm_we,
   output logic [AWIDTH-1:0] dm_addr,
   output logic [DWIDTH-1:0] dm_wdata,
   output logic [DWIDTH-1:0] exmem_aluresult,
   output logic [4:0]        exmem_dstaddr,
   output logic              exmem_regwr,
   output logic              pcload,
   output logic [AWIDTH-1:0] pcaddr,
   output logic              flush,
   output logic              stall,
   output logic              wb_regwr,
   output logic [1:0]        wb_memtoreg,
   output logic [4:0]        wb_dstaddr,
   output logic [DWIDTH-1:0] wb_aluresult,
   output logic [DWIDTH-1:0] wb_memdata,
   output logic [AWIDTH-1:0] wb_pcnext,
   output logic              memerr
);

   ctrl_t             ex_ctrl;
   ctrl_t             em_ctrl;
   logic [DWIDTH-1:0] em_alu;
   logic [DWIDTH-1:0] em_sd;
   logic [4:0]        em_dst;
   logic [AWIDTH-1:0] em_bra;
   logic [AWIDTH-1:0] em_jmp;
   logic [AWIDTH-1:0] em_pcn;

   logic memop;
   logic misal;
   logic amemop;
   logic zero;
   logic neg;
   logic taken;
   logic done;
   logic tmo;
   logic retire_bubble;

   assign ex_ctrl = '{
      memrd:    ex_memrd,
      memwr:    ex_memwr,
      bbeq:     ex_bbeq,
      bbne:     ex_bbne,
      bblez:    ex_bblez,
      bbgtz:    ex_bbgtz,
      jump:     ex_jump,
      regwr:    ex_regwr,
      memtoreg: ex_memtoreg
   };

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         em_ctrl <= CTRL_BUBBLE;
         em_alu  <= '0;
         em_sd   <= '0;
         em_dst  <= '0;
         em_bra  <= '0;
         em_jmp  <= '0;
         em_pcn  <= '0;
      end else if (!stall) begin
         if (flush) begin
            em_ctrl <= CTRL_BUBBLE;
            em_alu  <= '0;
            em_sd   <= '0;
            em_dst  <= '0;
            em_bra  <= '0;
            em_jmp  <= '0;
            em_pcn  <= '0;
         end else begin
            em_ctrl <= ex_ctrl;
            em_alu  <= ex_aluresult;
            em_sd   <= ex_storedata;
            em_dst  <= ex_dstaddr;
            em_bra  <= ex_branaddr;
            em_jmp  <= ex_jmpaddr;
            em_pcn  <= ex_pcnext;
         end
      end
   end

   assign zero   = (em_alu == '0);
   assign neg    = em_alu[DWIDTH-1];
   assign taken  = br_taken(em_ctrl, zero, neg);
   assign pcload = taken | em_ctrl.jump;
   assign pcaddr = em_ctrl.jump ? em_jmp : em_bra;
   assign flush  = pcload;

   assign memop  = em_ctrl.memrd | em_ctrl.memwr;
   assign misal  = memop & (em_alu[1:0] != 2'b00);
   assign amemop = memop & ~misal;

   dmem_fsm #(
      .TIMEOUT(TIMEOUT)
   ) u_fsm (
      .clk    (clk),
      .clr    (clr),
      .memop  (amemop),
      .dm_ack (dm_ack),
      .dm_req (dm_req),
      .stall  (stall),
      .done   (done),
      .tmo    (tmo)
   );

   assign dm_we    = em_ctrl.memwr;
   assign dm_addr  = AWIDTH'(em_alu);
   assign dm_wdata = em_sd;

   assign exmem_aluresult = em_alu;
   assign exmem_dstaddr   = em_dst;
   assign exmem_regwr     = em_ctrl.regwr;

   // failed or still-pending accesses must not write back
   assign retire_bubble = stall | misal | tmo;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         wb_regwr     <= 1'b0;
         wb_memtoreg  <= '0;
         wb_dstaddr   <= '0;
         wb_aluresult <= '0;
         wb_memdata   <= '0;
         wb_pcnext    <= '0;
      end else if (retire_bubble) begin
         wb_regwr     <= 1'b0;
         wb_memtoreg  <= '0;
         wb_dstaddr   <= '0;
         wb_aluresult <= '0;
         wb_memdata   <= '0;
         wb_pcnext    <= '0;
      end else begin
         wb_regwr     <= em_ctrl.regwr;
         wb_memtoreg  <= em_ctrl.memtoreg;
         wb_dstaddr   <= em_dst;
         wb_aluresult <= em_alu;
         wb_memdata   <= done ? dm_rdata : '0;
         wb_pcnext    <= em_pcn;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         memerr <= 1'b0;
      end else if (misal | tmo) begin
         memerr <= 1'b1;
      end
   end

endmodule

// File: tb/tb_exmem_stage.sv
// Scoreboard bench for exmem_stage: directed
// instructions, writeback/redirect monitors.
module tb_exmem_stage;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] ex_aluresult;
   logic [31:0] ex_storedata;
   logic [4:0]  ex_dstaddr;
   logic        ex_memrd;
   logic        ex_memwr;
   logic        ex_bbeq;
   logic        ex_bbne;
   logic        ex_bblez;
   logic        ex_bbgtz;
   logic        ex_jump;
   logic        ex_regwr;
   logic [1:0]  ex_memtoreg;
   logic [31:0] ex_branaddr;
   logic [31:0] ex_jmpaddr;
   logic [31:0] ex_pcnext;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] exmem_aluresult;
   logic [4:0]  exmem_dstaddr;
   logic        exmem_regwr;
   logic        pcload;
   logic [31:0] pcaddr;
   logic        flush;
   logic        stall;
   logic        wb_regwr;
   logic [1:0]  wb_memtoreg;
   logic [4:0]  wb_dstaddr;
   logic [31:0] wb_aluresult;
   logic [31:0] wb_memdata;
   logic [31:0] wb_pcnext;
   logic        memerr;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [4:0]  dst;
      logic [31:0] alu;
      logic [31:0] mem;
      logic [1:0]  mtr;
      logic [31:0] pcn;
   } wb_t;

   wb_t         wbq[$];
   logic [31:0] pcq[$];

   // ctrl bits: memrd memwr beq bne blez bgtz jump regwr
   localparam logic [7:0] C_LW   = 8'b1000_0001;
   localparam logic [7:0] C_SW   = 8'b0100_0000;
   localparam logic [7:0] C_BEQ  = 8'b0010_0000;
   localparam logic [7:0] C_BNE  = 8'b0001_0000;
   localparam logic [7:0] C_BLEZ = 8'b0000_1000;
   localparam logic [7:0] C_BGTZ = 8'b0000_0100;
   localparam logic [7:0] C_JAL  = 8'b0000_0011;
   localparam logic [7:0] C_ALU  = 8'b0000_0001;

   exmem_stage dut (
      .clk             (clk),
      .clr             (clr),
      .ex_aluresult    (ex_aluresult),
      .ex_storedata    (ex_storedata),
      .ex_dstaddr      (ex_dstaddr),
      .ex_memrd        (ex_memrd),
      .ex_memwr        (ex_memwr),
      .ex_bbeq         (ex_bbeq),
      .ex_bbne         (ex_bbne),
      .ex_bblez        (ex_bblez),
      .ex_bbgtz        (ex_bbgtz),
      .ex_jump         (ex_jump),
      .ex_regwr        (ex_regwr),
      .ex_memtoreg     (ex_memtoreg),
      .ex_branaddr     (ex_branaddr),
      .ex_jmpaddr      (ex_jmpaddr),
      .ex_pcnext       (ex_pcnext),
      .dm_rdata        (dm_rdata),
      .dm_ack          (dm_ack),
      .dm_req          (dm_req),
      .dm_we           (dm_we),
      .dm_addr         (dm_addr),
      .dm_wdata        (dm_wdata),
      .exmem_aluresult (exmem_aluresult),
      .exmem_dstaddr   (exmem_dstaddr),
      .exmem_regwr     (exmem_regwr),
      .pcload          (pcload),
      .pcaddr          (pcaddr),
      .flush           (flush),
      .stall           (stall),
      .wb_regwr        (wb_regwr),
      .wb_memtoreg     (wb_memtoreg),
      .wb_dstaddr      (wb_dstaddr),
      .wb_aluresult    (wb_aluresult),
      .wb_memdata      (wb_memdata),
      .wb_pcnext       (wb_pcnext),
      .memerr          (memerr)
   );

   always #5 clk = ~clk;

   task automatic chk(
      input string       name,
      input logic [63:0] act,
      input logic [63:0] exp
   );
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h",
                  name, act, exp);
      end
   endtask

   task automatic nop_in();
      {ex_memrd, ex_memwr, ex_bbeq, ex_bbne} = '0;
      {ex_bblez, ex_bbgtz, ex_jump, ex_regwr} = '0;
      ex_memtoreg  = '0;
      ex_aluresult = '0;
      ex_storedata = '0;
      ex_dstaddr   = '0;
      ex_branaddr  = '0;
      ex_jmpaddr   = '0;
      ex_pcnext    = '0;
   endtask

   task automatic drive(
      input logic [7:0]  c,
      input logic [1:0]  mtr,
      input logic [4:0]  dst,
      input logic [31:0] alu,
      input logic [31:0] sd,
      input logic [31:0] bra,
      input logic [31:0] jmp,
      input logic [31:0] pcn
   );
      {ex_memrd, ex_memwr, ex_bbeq, ex_bbne} = c[7:4];
      {ex_bblez, ex_bbgtz, ex_jump, ex_regwr} = c[3:0];
      ex_memtoreg  = mtr;
      ex_dstaddr   = dst;
      ex_aluresult = alu;
      ex_storedata = sd;
      ex_branaddr  = bra;
      ex_jmpaddr   = jmp;
      ex_pcnext    = pcn;
   endtask

   // load driven inputs, then sit in the cycle where the
   // instruction occupies EX/MEM
   task automatic step();
      @(posedge clk);
      #1;
      nop_in();
      @(negedge clk);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      @(negedge clk);
   endtask

   task automatic mem_wait(
      input  int          ack_on,
      input  logic [31:0] rdata,
      input  logic [31:0] addr,
      input  logic        we,
      input  logic [31:0] wd,
      output int          reqs,
      output int          stalls,
      output int          bad
   );
      bit done;
      reqs   = 0;
      stalls = 0;
      bad    = 0;
      done   = 0;
      for (int i = 0; i < 64 && !done; i++) begin
         if (dm_req) begin
            reqs++;
            if (dm_addr !== addr || dm_we !== we ||
                (we && dm_wdata !== wd))
               bad++;
            if (reqs == ack_on) begin
               dm_ack   = 1'b1;
               dm_rdata = rdata;
               #1;
            end
         end
         if (!stall) done = 1;
         else begin
            stalls++;
            @(negedge clk);
         end
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL mem_wait: stall still %0b after 64 cycles, required 0",
                  stall);
      end
      @(posedge clk);
      #1;
      dm_ack   = 1'b0;
      dm_rdata = '0;
      @(negedge clk);
   endtask

   initial begin : wb_monitor
      wb_t e;
      bit  ok;
      forever begin
         @(negedge clk);
         if (clr && wb_regwr) begin
            tests++;
            if (wbq.size() == 0) begin
               fails++;
               $display("FAIL wb_unexpected: got write r%0d=%0h, required none",
                        wb_dstaddr, wb_aluresult);
            end else begin
               e  = wbq.pop_front();
               ok = wb_dstaddr === e.dst &&
                    wb_aluresult === e.alu &&
                    wb_memtoreg === e.mtr &&
                    wb_pcnext === e.pcn &&
                    (e.mtr != 2'd1 || wb_memdata === e.mem);
               if (!ok) begin
                  fails++;
                  $display("FAIL wb_record: got r%0d alu %0h mem %0h mtr %0d pc %0h, required r%0d alu %0h mem %0h mtr %0d pc %0h",
                           wb_dstaddr, wb_aluresult, wb_memdata,
                           wb_memtoreg, wb_pcnext, e.dst, e.alu,
                           e.mem, e.mtr, e.pcn);
               end
            end
         end
      end
   end

   initial begin : pc_monitor
      logic [31:0] t;
      forever begin
         @(negedge clk);
         if (clr && pcload) begin
            tests++;
            if (pcq.size() == 0) begin
               fails++;
               $display("FAIL pc_unexpected: got redirect to %0h, required none",
                        pcaddr);
            end else begin
               t = pcq.pop_front();
               if (pcaddr !== t || flush !== 1'b1) begin
                  fails++;
                  $display("FAIL pc_redirect: got %0h flush %0b, required %0h flush 1",
                           pcaddr, flush, t);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int r;
      int s;
      int b;
      nop_in();
      dm_ack   = 1'b0;
      dm_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_ctrl",
          {dm_req, stall, pcload, flush,
           wb_regwr, exmem_regwr, memerr}, 0);
      chk("rst_wb", {wb_aluresult, wb_pcnext}, 0);
      @(posedge clk);
      #1 clr = 1'b1;
      @(negedge clk);

      wbq.push_back('{5'd4, 32'h1234, 32'h0, 2'd0, 32'h1008});
      drive(C_ALU, 2'd0, 5'd4, 32'h1234, 0, 0, 0, 32'h1008);
      step();
      chk("alu_tap", {exmem_regwr, exmem_dstaddr, exmem_aluresult},
          {1'b1, 5'd4, 32'h1234});
      chk("alu_nostall", {stall, dm_req}, 0);
      @(negedge clk);
      chk("alu_wb_lat1", wb_regwr, 1);

      wbq.push_back('{5'd3, 32'h100, 32'hDEADBEEF, 2'd1, 32'h1004});
      drive(C_LW, 2'd1, 5'd3, 32'h100, 0, 0, 0, 32'h1004);
      step();
      mem_wait(3, 32'hDEADBEEF, 32'h100, 1'b0, 0, r, s, b);
      chk("lw_stall_cyc", s, 3);
      chk("lw_req_cyc", r, 3);
      chk("lw_req_stable", b, 0);
      chk("lw_wb", {wb_regwr, wb_memdata}, {1'b1, 32'hDEADBEEF});
      @(negedge clk);
      chk("lw_wb_once", wb_regwr, 0);

      drive(C_SW, 2'd0, 5'd0, 32'h200, 32'hCAFEF00D, 0, 0, 32'h1010);
      step();
      mem_wait(1, 0, 32'h200, 1'b1, 32'hCAFEF00D, r, s, b);
      chk("sw_min_lat", {s[7:0], r[7:0]}, {8'd1, 8'd1});
      chk("sw_req_stable", b, 0);

      pcq.push_back(32'h40);
      drive(C_BEQ, 2'd0, 5'd0, 32'h0, 0, 32'h40, 32'h777, 32'h2004);
      step();
      chk("beq_taken", {pcload, flush, pcaddr}, {2'b11, 32'h40});
      drive(C_ALU, 2'd0, 5'd7, 32'h55, 0, 0, 0, 32'h2008);
      step();
      chk("beq_shadow_bubble", {exmem_regwr, exmem_dstaddr}, 0);

      drive(C_BEQ, 2'd0, 5'd0, 32'h1, 0, 32'h44, 0, 32'h2010);
      step();
      chk("beq_not_taken", pcload, 0);
      drive(C_BGTZ, 2'd0, 5'd0, 32'h80000000, 0, 32'h60, 0, 0);
      step();
      chk("bgtz_neg", pcload, 0);
      pcq.push_back(32'h60);
      drive(C_BLEZ, 2'd0, 5'd0, 32'h80000000, 0, 32'h60, 0, 0);
      step();
      chk("blez_neg", {pcload, pcaddr}, {1'b1, 32'h60});
      idle();
      pcq.push_back(32'h80);
      drive(C_BNE, 2'd0, 5'd0, 32'h5, 0, 32'h80, 0, 0);
      step();
      chk("bne_taken", {pcload, pcaddr}, {1'b1, 32'h80});
      idle();
      pcq.push_back(32'h90);
      drive(C_BGTZ, 2'd0, 5'd0, 32'h7, 0, 32'h90, 0, 0);
      step();
      chk("bgtz_pos", pcload, 1);
      idle();
      pcq.push_back(32'h2000);
      wbq.push_back('{5'd31, 32'h0, 32'h0, 2'd2, 32'h3004});
      drive(C_JAL, 2'd2, 5'd31, 32'h0, 0, 32'h40, 32'h2000, 32'h3004);
      step();
      chk("jal_target", {pcload, pcaddr}, {1'b1, 32'h2000});
      idle();

      chk("memerr_clean", memerr, 0);
      drive(C_LW, 2'd1, 5'd9, 32'h300, 0, 0, 0, 32'h4004);
      step();
      mem_wait(0, 0, 32'h300, 1'b0, 0, r, s, b);
      chk("tmo_req_cyc", r, 16);
      chk("tmo_stall_cyc", s, 16);
      chk("tmo_after", {memerr, stall, dm_req, wb_regwr},
          4'b1000);

      @(posedge clk);
      #1 clr = 1'b0;
      @(negedge clk);
      chk("rst2_memerr", memerr, 0);
      @(posedge clk);
      #1 clr = 1'b1;
      @(negedge clk);

      drive(C_SW, 2'd0, 5'd0, 32'h102, 32'h11, 0, 0, 0);
      step();
      chk("sw_misal_noreq", {dm_req, stall}, 0);
      @(negedge clk);
      chk("sw_misal_err", {memerr, wb_regwr}, 2'b10);
      drive(C_LW, 2'd1, 5'd6, 32'h101, 0, 0, 0, 32'h5004);
      step();
      chk("lw_misal_noreq", {dm_req, stall}, 0);
      @(negedge clk);
      chk("lw_misal_bubble", wb_regwr, 0);

      drive(C_LW, 2'd1, 5'd5, 32'h400, 0, 0, 0, 32'h6004);
      step();
      @(negedge clk);
      chk("rst_mid_req", dm_req, 1);
      clr = 1'b0;
      #1;
      chk("rst_mid_drop", {dm_req, stall, exmem_regwr, memerr}, 0);
      chk("rst_mid_wb",
          {wb_regwr, wb_memtoreg, wb_dstaddr, wb_aluresult}, 0);
      chk("rst_mid_wbd", {wb_memdata, wb_pcnext}, 0);
      @(posedge clk);
      #1 clr = 1'b1;
      @(negedge clk);
      dm_ack   = 1'b1;
      dm_rdata = 32'hBAD0BAD0;
      @(posedge clk);
      #1 dm_ack = 1'b0;
      @(negedge clk);
      chk("late_ack_ignored", {dm_req, stall, wb_regwr}, 0);

      chk("wbq_drained", wbq.size(), 0);
      chk("pcq_drained", pcq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
